// File: rtl/topk_result_serializer.sv
// Buffers the top-k result words of one query and replays them as a framed byte packet
// (count header, MSB-first data bytes, 0x0A trailer). Define TOPK_CHECKSUM_EN for an XOR checksum byte.
module topk_result_serializer #(
    parameter int K_MAX      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic                  result_valid_in,
    input  logic                  search_done_in,
    input  logic [15:0]           k_in,
    input  logic                  tx_ready_in,
    output logic [7:0]            tx_data_out,
    output logic                  tx_valid_out,
    output logic                  busy_out,
    output logic [7:0]            count_out,
    output logic                  overflow_out
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int AW    = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam logic [7:0] K_MAX_B      = 8'(K_MAX);
    localparam logic [7:0] TRAILER_BYTE = 8'h0A;

`ifdef TOPK_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_HEADER, S_SEND, S_CHECKSUM, S_TRAILER} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_HEADER, S_SEND, S_TRAILER} state_t;
`endif

    state_t                state_reg;
    logic [DATA_WIDTH-1:0] mem [K_MAX];
    logic [7:0]            count_reg;
    logic [7:0]            k_lat_reg;
    logic [7:0]            word_idx_reg;
    logic [BW-1:0]         byte_idx_reg;
    logic [7:0]            tx_data_reg;
    logic                  tx_valid_reg;
    logic                  overflow_reg;
`ifdef TOPK_CHECKSUM_EN
    logic [7:0]            chk_reg;
`endif

    logic [7:0]            k_eff;
    logic                  handshake;
    logic                  last_byte;
    logic                  last_word;
    logic [7:0]            next_w;
    logic [BW-1:0]         next_b;
    logic [7:0]            rd_w;
    logic [BW-1:0]         rd_b;
    logic [DATA_WIDTH-1:0] word_sel;
    logic [7:0]            word_bytes [BYTES];
    logic [7:0]            rd_byte;
    logic                  wr_en;
    logic [AW-1:0]         wr_idx;
    state_t                end_state;
    logic [7:0]            end_byte;

    always_comb begin
        k_eff     = (k_in > 16'(K_MAX)) ? K_MAX_B : k_in[7:0];
        handshake = tx_valid_reg && tx_ready_in;
        last_byte = (byte_idx_reg == BW'(BYTES - 1));
        last_word = (word_idx_reg == count_reg - 8'd1);
        next_w    = last_byte ? word_idx_reg + 8'd1 : word_idx_reg;
        next_b    = last_byte ? '0 : byte_idx_reg + BW'(1);
        // The header handshake preloads byte 0 of word 0; SEND preloads the byte after the current one.
        rd_w      = (state_reg == S_HEADER) ? 8'd0 : next_w;
        rd_b      = (state_reg == S_HEADER) ? '0 : next_b;
        wr_en     = result_valid_in &&
                    ((state_reg == S_IDLE) || (state_reg == S_COLLECT && count_reg < K_MAX_B));
        wr_idx    = (state_reg == S_IDLE) ? '0 : count_reg[AW-1:0];
`ifdef TOPK_CHECKSUM_EN
        end_state = S_CHECKSUM;
        end_byte  = chk_reg ^ tx_data_reg;
`else
        end_state = S_TRAILER;
        end_byte  = TRAILER_BYTE;
`endif
    end

    assign word_sel = mem[rd_w[AW-1:0]];

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_bytes
            assign word_bytes[gi] = word_sel[DATA_WIDTH-1-8*gi -: 8];
        end
    endgenerate

    assign rd_byte = word_bytes[rd_b];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_idx] <= result_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg    <= S_IDLE;
            count_reg    <= 8'd0;
            k_lat_reg    <= 8'd0;
            word_idx_reg <= 8'd0;
            byte_idx_reg <= '0;
            tx_data_reg  <= 8'd0;
            tx_valid_reg <= 1'b0;
            overflow_reg <= 1'b0;
`ifdef TOPK_CHECKSUM_EN
            chk_reg      <= 8'd0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (result_valid_in || search_done_in) begin
                        k_lat_reg    <= k_eff;
                        overflow_reg <= 1'b0;
                        word_idx_reg <= 8'd0;
                        byte_idx_reg <= '0;
`ifdef TOPK_CHECKSUM_EN
                        chk_reg      <= 8'd0;
`endif
                        if (result_valid_in) begin
                            count_reg <= 8'd1;
                            state_reg <= (search_done_in || k_eff == 8'd1) ? S_HEADER : S_COLLECT;
                        end else begin
                            count_reg <= 8'd0;
                            state_reg <= S_HEADER;
                        end
                    end
                end
                S_COLLECT: begin
                    if (result_valid_in) begin
                        if (count_reg == K_MAX_B) begin
                            overflow_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + 8'd1;
                        end
                    end
                    if (search_done_in ||
                        (result_valid_in && count_reg != K_MAX_B && count_reg + 8'd1 == k_lat_reg)) begin
                        state_reg <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (result_valid_in) begin
                        overflow_reg <= 1'b1;
                    end
                    if (!tx_valid_reg) begin
                        tx_valid_reg <= 1'b1;
                        tx_data_reg  <= count_reg;
                    end else if (tx_ready_in) begin
`ifdef TOPK_CHECKSUM_EN
                        chk_reg <= chk_reg ^ tx_data_reg;
`endif
                        if (count_reg == 8'd0) begin
                            state_reg   <= end_state;
                            tx_data_reg <= end_byte;
                        end else begin
                            state_reg    <= S_SEND;
                            tx_data_reg  <= rd_byte;
                            word_idx_reg <= 8'd0;
                            byte_idx_reg <= '0;
                        end
                    end
                end
                S_SEND: begin
                    if (result_valid_in) begin
                        overflow_reg <= 1'b1;
                    end
                    if (handshake) begin
`ifdef TOPK_CHECKSUM_EN
                        chk_reg <= chk_reg ^ tx_data_reg;
`endif
                        if (last_byte && last_word) begin
                            state_reg   <= end_state;
                            tx_data_reg <= end_byte;
                        end else begin
                            tx_data_reg  <= rd_byte;
                            word_idx_reg <= next_w;
                            byte_idx_reg <= next_b;
                        end
                    end
                end
`ifdef TOPK_CHECKSUM_EN
                S_CHECKSUM: begin
                    if (result_valid_in) begin
                        overflow_reg <= 1'b1;
                    end
                    if (handshake) begin
                        state_reg   <= S_TRAILER;
                        tx_data_reg <= TRAILER_BYTE;
                    end
                end
`endif
                S_TRAILER: begin
                    if (result_valid_in) begin
                        overflow_reg <= 1'b1;
                    end
                    if (handshake) begin
                        state_reg    <= S_IDLE;
                        tx_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    tx_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data_out  = tx_data_reg;
    assign tx_valid_out = tx_valid_reg;
    assign busy_out     = (state_reg != S_IDLE);
    assign count_out    = count_reg;
    assign overflow_out = overflow_reg;

endmodule

// File: tb/tb_topk_result_serializer.sv
// Directed bench for topk_result_serializer: instance A uses K_MAX=16, instance B uses K_MAX=2.
module tb_topk_result_serializer;

    typedef logic [7:0] byte_q_t[$];

    logic        clk_in = 1'b0;
    logic        rst_n;
    // instance A
    logic [31:0] a_result;
    logic        a_valid, a_done, a_ready;
    logic [15:0] a_k;
    logic [7:0]  a_data, a_count;
    logic        a_tx_valid, a_busy, a_ovf;
    // instance B
    logic [31:0] b_result;
    logic        b_valid, b_done, b_ready;
    logic [15:0] b_k;
    logic [7:0]  b_data, b_count;
    logic        b_tx_valid, b_busy, b_ovf;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    int pat = 0;
    byte_q_t rx_q, rxb_q, exp_q;
    int hs_cyc_q[$];
    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = 8'd0;

    topk_result_serializer #(.K_MAX(16), .DATA_WIDTH(32)) dut_a (
        .clk_in(clk_in), .rst_in(rst_n), .result_in(a_result), .result_valid_in(a_valid),
        .search_done_in(a_done), .k_in(a_k), .tx_ready_in(a_ready), .tx_data_out(a_data),
        .tx_valid_out(a_tx_valid), .busy_out(a_busy), .count_out(a_count), .overflow_out(a_ovf)
    );

    topk_result_serializer #(.K_MAX(2), .DATA_WIDTH(32)) dut_b (
        .clk_in(clk_in), .rst_in(rst_n), .result_in(b_result), .result_valid_in(b_valid),
        .search_done_in(b_done), .k_in(b_k), .tx_ready_in(b_ready), .tx_data_out(b_data),
        .tx_valid_out(b_tx_valid), .busy_out(b_busy), .count_out(b_count), .overflow_out(b_ovf)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    // Ready pattern 1,0,0 repeating in mode 1, otherwise held high.
    always @(posedge clk_in) begin
        #1;
        if (ready_mode == 1) begin
            a_ready = (pat == 0);
            pat = (pat == 2) ? 0 : pat + 1;
        end else begin
            a_ready = 1'b1;
            pat = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check_eq("stall_valid", {31'd0, a_tx_valid}, 32'd1);
                check_eq("stall_data", {24'd0, a_data}, {24'd0, stall_data});
            end
            if (a_tx_valid && a_ready) begin
                rx_q.push_back(a_data);
                hs_cyc_q.push_back(cyc);
            end
            stall_pend = a_tx_valid && !a_ready;
            stall_data = a_data;
            if (b_tx_valid && b_ready) rxb_q.push_back(b_data);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_a(input logic [31:0] w, input logic v, input logic d);
        a_result = w; a_valid = v; a_done = d;
        tick();
        a_valid = 1'b0; a_done = 1'b0;
    endtask

    task automatic drive_b(input logic [31:0] w, input logic v, input logic d);
        b_result = w; b_valid = v; b_done = d;
        tick();
        b_valid = 1'b0; b_done = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (a_busy && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        check_eq(tag, {31'd0, a_busy}, 32'd0);
    endtask

    task automatic wait_idle_b(input string tag);
        int n = 0;
        while (b_busy && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        check_eq(tag, {31'd0, b_busy}, 32'd0);
    endtask

    task automatic compare_pkt(input string tag, input byte_q_t got, input byte_q_t exp);
        check_eq($sformatf("%s_len", tag), got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
        $display("packet %s: %0d bytes", tag, got.size());
    endtask

    task automatic three_word_stream();
        a_k = 16'd3;
        drive_a(32'h11223344, 1'b1, 1'b0);
        drive_a(32'h55667788, 1'b1, 1'b0);
        drive_a(32'h0000000A, 1'b1, 1'b0);
        drive_a(32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_result = '0; a_valid = 0; a_done = 0; a_k = '0; a_ready = 1'b1;
        b_result = '0; b_valid = 0; b_done = 0; b_k = '0; b_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check_eq("rst_valid", {31'd0, a_tx_valid}, 32'd0);
        check_eq("rst_data", {24'd0, a_data}, 32'd0);
        check_eq("rst_busy", {31'd0, a_busy}, 32'd0);
        check_eq("rst_count", {24'd0, a_count}, 32'd0);
        check_eq("rst_ovf", {31'd0, a_ovf}, 32'd0);
        check_eq("rst_b_valid", {31'd0, b_tx_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 3-word packet, ready held high: back-to-back bytes
        rx_q.delete(); hs_cyc_q.delete();
        three_word_stream();
        wait_idle_a("t1_idle");
        exp_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h0A};
`ifdef TOPK_CHECKSUM_EN
        exp_q.push_back(8'h81);
`endif
        exp_q.push_back(8'h0A);
        compare_pkt("t1", rx_q, exp_q);
        if (hs_cyc_q.size() > 0)
            check_eq("t1_span", hs_cyc_q[hs_cyc_q.size()-1] - hs_cyc_q[0], exp_q.size() - 1);
        check_eq("t1_count", {24'd0, a_count}, 32'd3);
        check_eq("t1_ovf", {31'd0, a_ovf}, 32'd0);
        tick();
        check_eq("t1_busy_after", {31'd0, a_busy}, 32'd0);

        // same stream under 1,0,0 backpressure
        rx_q.delete(); hs_cyc_q.delete();
        ready_mode = 1;
        three_word_stream();
        wait_idle_a("t2_idle");
        ready_mode = 0;
        compare_pkt("t2", rx_q, exp_q);
        tick();

        // search_done alone: empty packet
        rx_q.delete();
        a_k = 16'd4;
        drive_a(32'h0, 1'b0, 1'b1);
        wait_idle_a("t3_idle");
        exp_q = '{8'h00};
`ifdef TOPK_CHECKSUM_EN
        exp_q.push_back(8'h00);
`endif
        exp_q.push_back(8'h0A);
        compare_pkt("t3", rx_q, exp_q);
        check_eq("t3_count", {24'd0, a_count}, 32'd0);
        tick();

        // k=1: second word lands in HEADER and is dropped
        rx_q.delete();
        a_k = 16'd1;
        drive_a(32'h12345678, 1'b1, 1'b0);
        drive_a(32'h9ABCDEF0, 1'b1, 1'b0);
        wait_idle_a("t5_idle");
        exp_q = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef TOPK_CHECKSUM_EN
        exp_q.push_back(8'h09);
`endif
        exp_q.push_back(8'h0A);
        compare_pkt("t5", rx_q, exp_q);
        check_eq("t5_ovf", {31'd0, a_ovf}, 32'd1);
        check_eq("t5_count", {24'd0, a_count}, 32'd1);
        tick();

        // K_MAX=2 instance, k=5, three words
        rxb_q.delete();
        b_k = 16'd5;
        drive_b(32'h01020304, 1'b1, 1'b0);
        drive_b(32'h05060708, 1'b1, 1'b0);
        drive_b(32'h090A0B0C, 1'b1, 1'b0);
        drive_b(32'h0, 1'b0, 1'b1);
        wait_idle_b("t4_idle");
        exp_q = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef TOPK_CHECKSUM_EN
        exp_q.push_back(8'h0A);
`endif
        exp_q.push_back(8'h0A);
        compare_pkt("t4", rxb_q, exp_q);
        check_eq("t4_ovf", {31'd0, b_ovf}, 32'd1);
        check_eq("t4_count", {24'd0, b_count}, 32'd2);
        tick();
        rxb_q.delete();
        drive_b(32'hAABBCCDD, 1'b1, 1'b1);
        check_eq("t4_ovf_clear", {31'd0, b_ovf}, 32'd0);
        check_eq("t4_busy", {31'd0, b_busy}, 32'd1);
        wait_idle_b("t4b_idle");
        exp_q = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef TOPK_CHECKSUM_EN
        exp_q.push_back(8'h01 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
        exp_q.push_back(8'h0A);
        compare_pkt("t4b", rxb_q, exp_q);
        tick();

        // reset in the middle of SEND, then a fresh packet
        rx_q.delete();
        three_word_stream();
        for (int i = 0; i < 100 && rx_q.size() < 5; i++) @(negedge clk_in);
        check_eq("t6_reached_send", (rx_q.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", {31'd0, a_tx_valid}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, a_busy}, 32'd0);
        check_eq("t6_rst_count", {24'd0, a_count}, 32'd0);
        check_eq("t6_rst_data", {24'd0, a_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rx_q.delete();
        a_k = 16'd1;
        drive_a(32'hDEADBEEF, 1'b1, 1'b0);
        wait_idle_a("t6_idle");
        exp_q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef TOPK_CHECKSUM_EN
        exp_q.push_back(8'h23);
`endif
        exp_q.push_back(8'h0A);
        compare_pkt("t6", rx_q, exp_q);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
